// File: rtl/rx_frame_ctrl_if.sv
// rtl/rx_frame_ctrl_if.sv - UART-side byte strobe and frame-consumer signal bundle
//
// Ports (slave = rx_frame_ctrl view):
//   RxData, Rx_Done_Sig      byte and byte-received strobe from the UART receiver
//   Rx_En_Sig                receive enable back to the UART receiver
//   frame_valid, frame_len   held-frame status towards the consumer
//   frame_ack                consumer release of the held frame
//   rd_addr, rd_data         payload buffer read port (1-cycle latency)
//   err_pulse, err_code      one-cycle frame error strobe and its cause
interface rx_frame_ctrl_if;
    logic [7:0] RxData;
    logic       Rx_Done_Sig;
    logic       Rx_En_Sig;
    logic       frame_valid;
    logic [4:0] frame_len;
    logic       frame_ack;
    logic [3:0] rd_addr;
    logic [7:0] rd_data;
    logic       err_pulse;
    logic [1:0] err_code;

    modport master (
        output RxData,
        output Rx_Done_Sig,
        output frame_ack,
        output rd_addr,
        input  Rx_En_Sig,
        input  frame_valid,
        input  frame_len,
        input  rd_data,
        input  err_pulse,
        input  err_code
    );

    modport slave (
        input  RxData,
        input  Rx_Done_Sig,
        input  frame_ack,
        input  rd_addr,
        output Rx_En_Sig,
        output frame_valid,
        output frame_len,
        output rd_data,
        output err_pulse,
        output err_code
    );
endinterface

// File: rtl/rx_frame_ctrl.sv
// rtl/rx_frame_ctrl.sv - UART frame receiver: header sync, length, payload buffer, checksum
//
// Frame: HDR0 HDR1 LEN payload[LEN] CSUM, CSUM = (LEN + sum(payload)) mod 256.
// Ports:
//   clk     system clock
//   reset   asynchronous active-low reset
//   bus     rx_frame_ctrl_if.slave (UART byte input, frame status, buffer read port, errors)
// DEPTH is limited to 1..16 by the 4-bit rd_addr and 5-bit frame_len.
module rx_frame_ctrl #(
    parameter int         DEPTH       = 16,
    parameter int         TIMEOUT_CYC = 153600,
    parameter logic [7:0] HDR0        = 8'h5A,
    parameter logic [7:0] HDR1        = 8'hA5
) (
    input logic           clk,
    input logic           reset,
    rx_frame_ctrl_if.slave bus
);

    localparam int              TW       = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0]   TMO_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [7:0]      DEPTH8   = 8'(DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        GOT_H0,
        GET_LEN,
        GET_DATA,
        GET_CSUM,
        HOLD
    } state_t;

    state_t        state;
    logic          rx_done_q;
    logic [TW-1:0] tmo_cnt;
    logic [7:0]    acc;
    logic [3:0]    idx;
    logic [4:0]    len;
    logic [7:0]    mem [0:15];

    logic byte_evt;
    logic counting;
    logic tmo_hit;
    logic wr_en;

    // A held-high strobe produces exactly one byte event.
    assign byte_evt = bus.Rx_Done_Sig & ~rx_done_q;
    assign counting = (state == GOT_H0) || (state == GET_LEN) ||
                      (state == GET_DATA) || (state == GET_CSUM);
    // The counter reaches TIMEOUT_CYC on the edge where it sits at TIMEOUT_CYC-1.
    assign tmo_hit  = counting && (tmo_cnt == TMO_LAST);
    // A byte landing on the timeout cycle is dropped, including its buffer write.
    assign wr_en    = (state == GET_DATA) && byte_evt && !tmo_hit;

    // Payload buffer is deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[idx] <= bus.RxData;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= IDLE;
            rx_done_q       <= 1'b0;
            tmo_cnt         <= '0;
            acc             <= 8'd0;
            idx             <= 4'd0;
            len             <= 5'd0;
            bus.Rx_En_Sig   <= 1'b0;
            bus.frame_valid <= 1'b0;
            bus.frame_len   <= 5'd0;
            bus.rd_data     <= 8'd0;
            bus.err_pulse   <= 1'b0;
            bus.err_code    <= 2'd0;
        end else begin
            rx_done_q     <= bus.Rx_Done_Sig;
            bus.rd_data   <= mem[bus.rd_addr];
            bus.err_pulse <= 1'b0;
            bus.Rx_En_Sig <= 1'b1;

            if (tmo_hit) begin
                state         <= IDLE;
                tmo_cnt       <= '0;
                bus.err_pulse <= 1'b1;
                bus.err_code  <= 2'd3;
            end else begin
                if (counting) begin
                    tmo_cnt <= byte_evt ? '0 : tmo_cnt + 1'b1;
                end else begin
                    tmo_cnt <= '0;
                end

                case (state)
                    IDLE: begin
                        if (byte_evt && bus.RxData == HDR0) begin
                            state <= GOT_H0;
                        end
                    end
                    GOT_H0: begin
                        if (byte_evt) begin
                            if (bus.RxData == HDR1) begin
                                state <= GET_LEN;
                            end else if (bus.RxData != HDR0) begin
                                state <= IDLE;
                            end
                        end
                    end
                    GET_LEN: begin
                        if (byte_evt) begin
                            if (bus.RxData != 8'd0 && bus.RxData <= DEPTH8) begin
                                len   <= bus.RxData[4:0];
                                idx   <= 4'd0;
                                acc   <= bus.RxData;
                                state <= GET_DATA;
                            end else begin
                                bus.err_pulse <= 1'b1;
                                bus.err_code  <= 2'd1;
                                state         <= IDLE;
                            end
                        end
                    end
                    GET_DATA: begin
                        if (byte_evt) begin
                            acc <= acc + bus.RxData;
                            // idx stops at LEN-1, so it never passes DEPTH-1.
                            if ({1'b0, idx} == len - 5'd1) begin
                                state <= GET_CSUM;
                            end else begin
                                idx <= idx + 4'd1;
                            end
                        end
                    end
                    GET_CSUM: begin
                        if (byte_evt) begin
                            if (bus.RxData == acc) begin
                                state           <= HOLD;
                                bus.frame_valid <= 1'b1;
                                bus.frame_len   <= len;
                                bus.Rx_En_Sig   <= 1'b0;
                            end else begin
                                bus.err_pulse <= 1'b1;
                                bus.err_code  <= 2'd2;
                                state         <= IDLE;
                            end
                        end
                    end
                    HOLD: begin
                        if (bus.frame_ack) begin
                            bus.frame_valid <= 1'b0;
                            state           <= IDLE;
                        end else begin
                            bus.Rx_En_Sig <= 1'b0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rx_frame_ctrl.sv
// tb/tb_rx_frame_ctrl.sv - directed self-checking bench for rx_frame_ctrl
module tb_rx_frame_ctrl;

    localparam int T = 40;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   nvec = 0;
    int   nfail = 0;
    int   err_cnt = 0;

    always #5 clk = ~clk;

    rx_frame_ctrl_if bus ();

    rx_frame_ctrl #(
        .DEPTH      (16),
        .TIMEOUT_CYC(T),
        .HDR0       (8'h5A),
        .HDR1       (8'hA5)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always @(negedge clk) begin
        if (bus.err_pulse) err_cnt = err_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec = nvec + 1;
        assert (obs === exp) else begin
            nfail = nfail + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input int hold);
        @(negedge clk);
        bus.RxData      = b;
        bus.Rx_Done_Sig = 1'b1;
        repeat (hold) @(negedge clk);
        bus.Rx_Done_Sig = 1'b0;
    endtask

    task automatic send_seq(input logic [7:0] q[$], input int hold);
        foreach (q[i]) send(q[i], hold);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic rd_chk(input string tag, input logic [3:0] a, input logic [7:0] exp);
        @(negedge clk);
        bus.rd_addr = a;
        @(negedge clk);
        chk(tag, {24'd0, bus.rd_data}, {24'd0, exp});
    endtask

    task automatic ack;
        @(negedge clk);
        bus.frame_ack = 1'b1;
        @(negedge clk);
        bus.frame_ack = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_en"},    {31'd0, bus.Rx_En_Sig},   32'd0);
        chk({tag, "_valid"}, {31'd0, bus.frame_valid}, 32'd0);
        chk({tag, "_len"},   {27'd0, bus.frame_len},   32'd0);
        chk({tag, "_errp"},  {31'd0, bus.err_pulse},   32'd0);
        chk({tag, "_errc"},  {30'd0, bus.err_code},    32'd0);
        chk({tag, "_rd"},    {24'd0, bus.rd_data},     32'd0);
    endtask

    initial begin
        bus.RxData      = 8'd0;
        bus.Rx_Done_Sig = 1'b0;
        bus.frame_ack   = 1'b0;
        bus.rd_addr     = 4'd0;

        // Reset values, then receive enable rises on the first edge after release.
        idle(2);
        chk_reset_vals("rst");
        reset = 1'b1;
        idle(1);
        chk("rst_en_rise", {31'd0, bus.Rx_En_Sig}, 32'd1);

        // Good frame, 1-cycle strobes.
        send_seq('{8'h5A, 8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69}, 1);
        chk("f1_valid", {31'd0, bus.frame_valid}, 32'd1);
        chk("f1_len",   {27'd0, bus.frame_len},   32'd3);
        chk("f1_en",    {31'd0, bus.Rx_En_Sig},   32'd0);
        rd_chk("f1_rd0", 4'd0, 8'h11);
        rd_chk("f1_rd1", 4'd1, 8'h22);
        rd_chk("f1_rd2", 4'd2, 8'h33);
        // Bytes during HOLD are ignored.
        send_seq('{8'h5A, 8'hA5, 8'h01, 8'h44, 8'h45}, 1);
        idle(2);
        rd_chk("hold_rd0", 4'd0, 8'h11);
        chk("hold_valid", {31'd0, bus.frame_valid}, 32'd1);
        chk("hold_len",   {27'd0, bus.frame_len},   32'd3);
        ack();
        chk("ack_valid", {31'd0, bus.frame_valid}, 32'd0);
        chk("ack_en",    {31'd0, bus.Rx_En_Sig},   32'd1);
        chk("f1_errs",   err_cnt, 32'd0);

        // Bad checksum, then a good frame.
        send_seq('{8'h5A, 8'hA5, 8'h02, 8'h10, 8'h20, 8'h00}, 1);
        idle(2);
        chk("csum_errcnt", err_cnt, 32'd1);
        chk("csum_code",   {30'd0, bus.err_code},    32'd2);
        chk("csum_valid",  {31'd0, bus.frame_valid}, 32'd0);
        send_seq('{8'h5A, 8'hA5, 8'h02, 8'h10, 8'h20, 8'h32}, 1);
        chk("f2_valid", {31'd0, bus.frame_valid}, 32'd1);
        chk("f2_len",   {27'd0, bus.frame_len},   32'd2);
        rd_chk("f2_rd1", 4'd1, 8'h20);
        ack();

        // Length errors: 0 and DEPTH+1.
        send_seq('{8'h5A, 8'hA5, 8'h00}, 1);
        idle(2);
        chk("len0_errcnt", err_cnt, 32'd2);
        chk("len0_code",   {30'd0, bus.err_code}, 32'd1);
        send_seq('{8'h5A, 8'hA5, 8'h11}, 1);
        idle(2);
        chk("len17_errcnt", err_cnt, 32'd3);
        chk("len17_code",   {30'd0, bus.err_code}, 32'd1);

        // Repeated HDR0 keeps header sync.
        send_seq('{8'h5A, 8'h5A, 8'hA5, 8'h01, 8'h07, 8'h08}, 1);
        chk("f3_valid", {31'd0, bus.frame_valid}, 32'd1);
        chk("f3_len",   {27'd0, bus.frame_len},   32'd1);
        rd_chk("f3_rd0", 4'd0, 8'h07);
        ack();

        // Timeout fires exactly TIMEOUT_CYC edges after the last byte.
        send_seq('{8'h5A, 8'hA5, 8'h04, 8'h01}, 1);
        idle(T - 1);
        chk("tmo_early", {31'd0, bus.err_pulse}, 32'd0);
        idle(1);
        chk("tmo_pulse", {31'd0, bus.err_pulse}, 32'd1);
        chk("tmo_code",  {30'd0, bus.err_code},  32'd3);
        idle(2);
        chk("tmo_errcnt", err_cnt, 32'd4);
        idle(2 * T);
        chk("idle_noerr", err_cnt, 32'd4);

        // Byte on the timeout cycle is discarded; trailing bytes then land in IDLE.
        send(8'h5A, 1);
        idle(T - 2);
        send(8'hA5, 1);
        idle(3);
        chk("tie_errcnt", err_cnt, 32'd5);
        chk("tie_code",   {30'd0, bus.err_code}, 32'd3);
        send_seq('{8'h01, 8'h07, 8'h08}, 1);
        idle(2);
        chk("tie_valid", {31'd0, bus.frame_valid}, 32'd0);

        // Strobe held 5 cycles per byte.
        send_seq('{8'h5A, 8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69}, 5);
        chk("f5_valid", {31'd0, bus.frame_valid}, 32'd1);
        chk("f5_len",   {27'd0, bus.frame_len},   32'd3);
        rd_chk("f5_rd0", 4'd0, 8'h11);
        rd_chk("f5_rd2", 4'd2, 8'h33);
        ack();
        chk("f5_errcnt", err_cnt, 32'd5);

        // Reset mid-frame.
        send_seq('{8'h5A, 8'hA5, 8'h03, 8'h11}, 1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk_reset_vals("mid");
        idle(2);
        reset = 1'b1;
        idle(1);
        chk("mid_en_rise", {31'd0, bus.Rx_En_Sig}, 32'd1);
        chk("mid_errcnt",  err_cnt, 32'd5);
        send_seq('{8'h5A, 8'hA5, 8'h02, 8'hAB, 8'hCD, 8'h7A}, 1);
        chk("f6_valid", {31'd0, bus.frame_valid}, 32'd1);
        chk("f6_len",   {27'd0, bus.frame_len},   32'd2);
        rd_chk("f6_rd1", 4'd1, 8'hCD);
        ack();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
